// File: rtl/vmac_unit_pkg.sv
// Shared constants, opcodes and state encoding for the vector MAC unit.
package vmac_unit_pkg;

  localparam int unsigned VMAC_VLEN  = 256;
  localparam int unsigned VMAC_ELEN  = 32;
  localparam int unsigned VMAC_LANES = VMAC_VLEN / VMAC_ELEN;

  localparam int unsigned ALU_OP_W = 5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD     = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_VMAC_LW = 5'd20;
  localparam logic [ALU_OP_W-1:0] ALU_OP_VMAC_EN = 5'd21;
  localparam logic [ALU_OP_W-1:0] ALU_OP_VMAC_SW = 5'd22;

  typedef enum logic {
    VMAC_ST_IDLE = 1'b0,
    VMAC_ST_MAC  = 1'b1
  } vmac_state_t;

endpackage

// File: rtl/vmac_seq_dot.sv
// Serial dot product: one lane multiply per cycle through a single multiplier.
module vmac_seq_dot
  import vmac_unit_pkg::*;
#(
  parameter int unsigned ELEN  = VMAC_ELEN,
  parameter int unsigned LANES = VMAC_LANES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    flush,
  input  logic [LANES*ELEN-1:0]   vs1,
  input  logic [LANES*ELEN-1:0]   vs2,
  output logic                    done,
  output logic [ELEN-1:0]         sum
);

  localparam int unsigned LANE_W = $clog2(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [LANES-1:0][ELEN-1:0] vs1_q;
  logic [LANES-1:0][ELEN-1:0] vs2_q;
  logic [LANE_W-1:0]          lane_cnt;
  logic [ELEN-1:0]            partial;
  logic [ELEN-1:0]            prod;
  logic                       active;
  logic                       last;

  // Only the low ELEN bits of the product are kept (modulo arithmetic).
  assign prod = vs1_q[lane_cnt] * vs2_q[lane_cnt];
  assign last = (lane_cnt == LAST_LANE);
  assign sum  = partial + prod;
  assign done = active & last & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs1_q    <= '0;
      vs2_q    <= '0;
      lane_cnt <= '0;
      partial  <= '0;
      active   <= 1'b0;
    end else if (start) begin
      vs1_q    <= vs1;
      vs2_q    <= vs2;
      lane_cnt <= '0;
      partial  <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (flush || last) begin
        lane_cnt <= '0;
        partial  <= '0;
        active   <= 1'b0;
      end else begin
        partial  <= sum;
        lane_cnt <= lane_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vmac_unit.sv
// Vector multiply-accumulate unit: accumulator file, op handshake and result register.
module vmac_unit
  import vmac_unit_pkg::*;
#(
  parameter int unsigned VLEN = VMAC_VLEN,
  parameter int unsigned ELEN = VMAC_ELEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [ALU_OP_W-1:0] alu_opcode_i,
  input  logic [VLEN-1:0]     operand_vs1_i,
  input  logic [VLEN-1:0]     operand_vs2_i,
  input  logic [2:0]          vmac_sel_i,
  input  logic                flush_i,
  output logic                busy_o,
  output logic [VLEN-1:0]     result_o,
  output logic                result_valid_o
);

  localparam int unsigned LANES = VLEN / ELEN;

  vmac_state_t                state;
  logic [LANES-1:0][ELEN-1:0] acc;
  logic [2:0]                 sel_q;
  logic                       accept;
  logic                       dot_start;
  logic                       dot_done;
  logic [ELEN-1:0]            dot_sum;

  assign ready_o   = (state == VMAC_ST_IDLE);
  assign busy_o    = (state == VMAC_ST_MAC);
  // Flush in IDLE suppresses acceptance for that cycle.
  assign accept    = valid_i & ready_o & ~flush_i;
  assign dot_start = accept & (alu_opcode_i == ALU_OP_VMAC_EN);

  vmac_seq_dot #(
    .ELEN  (ELEN),
    .LANES (LANES)
  ) u_dot (
    .clk   (clk),
    .rst   (rst),
    .start (dot_start),
    .flush (flush_i),
    .vs1   (operand_vs1_i),
    .vs2   (operand_vs2_i),
    .done  (dot_done),
    .sum   (dot_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= VMAC_ST_IDLE;
      acc            <= '0;
      sel_q          <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
    end else begin
      result_valid_o <= 1'b0;
      case (state)
        VMAC_ST_IDLE: begin
          if (accept) begin
            case (alu_opcode_i)
              ALU_OP_VMAC_LW: acc <= operand_vs1_i;
              ALU_OP_VMAC_SW: begin
                result_o       <= acc;
                result_valid_o <= 1'b1;
              end
              ALU_OP_VMAC_EN: begin
                sel_q <= vmac_sel_i;
                state <= VMAC_ST_MAC;
              end
              default: ;
            endcase
          end
        end
        VMAC_ST_MAC: begin
          if (flush_i) begin
            state <= VMAC_ST_IDLE;
          end else if (dot_done) begin
            acc[sel_q] <= acc[sel_q] + dot_sum;
            state      <= VMAC_ST_IDLE;
          end
        end
        default: state <= VMAC_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmac_unit.sv
// Directed bench for vmac_unit with hand-computed expected accumulator values.
module tb_vmac_unit;
  import vmac_unit_pkg::*;

  logic                clk;
  logic                rst;
  logic                valid_i;
  logic                ready_o;
  logic [ALU_OP_W-1:0] alu_opcode_i;
  logic [255:0]        operand_vs1_i;
  logic [255:0]        operand_vs2_i;
  logic [2:0]          vmac_sel_i;
  logic                flush_i;
  logic                busy_o;
  logic [255:0]        result_o;
  logic                result_valid_o;

  int vectors;
  int miscompares;
  int n;

  vmac_unit #(.VLEN(256), .ELEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .alu_opcode_i   (alu_opcode_i),
    .operand_vs1_i  (operand_vs1_i),
    .operand_vs2_i  (operand_vs2_i),
    .vmac_sel_i     (vmac_sel_i),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] ramp(input int unsigned base, input int unsigned step);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(base + step * i);
    return v;
  endfunction

  function automatic logic [255:0] one_lane(input int unsigned idx, input logic [31:0] val);
    logic [255:0] v;
    v = '0;
    v[idx*32 +: 32] = val;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [ALU_OP_W-1:0] op, input logic [255:0] a,
                       input logic [255:0] b, input logic [2:0] sel);
    valid_i       = 1'b1;
    alu_opcode_i  = op;
    operand_vs1_i = a;
    operand_vs2_i = b;
    vmac_sel_i    = sel;
    tick();
    valid_i       = 1'b0;
  endtask

  task automatic wait_mac();
    for (int k = 0; k < 8; k++) tick();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    alu_opcode_i = ALU_OP_ADD; operand_vs1_i = '0; operand_vs2_i = '0; vmac_sel_i = '0;
    tick(); tick();
    chk("rst_ready", 256'(ready_o), 256'(1));
    chk("rst_busy", 256'(busy_o), 256'(0));
    chk("rst_rvalid", 256'(result_valid_o), 256'(0));
    chk("rst_result", result_o, '0);
    rst = 1'b1;
    tick();

    // LW then SW
    issue(ALU_OP_VMAC_LW, ramp(1, 1), '0, 3'd0);
    issue(ALU_OP_VMAC_SW, '0, '0, 3'd0);
    chk("lwsw_rvalid", 256'(result_valid_o), 256'(1));
    chk("lwsw_result", result_o, ramp(1, 1));
    tick();
    chk("lwsw_rvalid_drop", 256'(result_valid_o), 256'(0));
    chk("lwsw_result_hold", result_o, ramp(1, 1));

    // EN accumulation into acc[3]: 2*(1+..+8) = 72
    issue(ALU_OP_VMAC_LW, '0, '0, 3'd0);
    issue(ALU_OP_VMAC_EN, ramp(2, 0), ramp(1, 1), 3'd3);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (ready_o === 1'b0) n++;
      tick();
    end
    chk("en_busy_cycles", 256'(n), 256'(8));
    chk("en_ready_back", 256'(ready_o), 256'(1));
    issue(ALU_OP_VMAC_SW, '0, '0, 3'd0);
    chk("en_result_72", result_o, one_lane(3, 32'd72));
    issue(ALU_OP_VMAC_EN, ramp(2, 0), ramp(1, 1), 3'd3);
    wait_mac();
    issue(ALU_OP_VMAC_SW, '0, '0, 3'd0);
    chk("en_result_144", result_o, one_lane(3, 32'd144));

    // Backpressure: SW held during EN, accepted 9 cycles after the EN accept
    issue(ALU_OP_VMAC_EN, ramp(2, 0), ramp(1, 1), 3'd3);
    valid_i = 1'b1; alu_opcode_i = ALU_OP_VMAC_SW;
    n = 0;
    do begin
      tick();
      n++;
    end while (result_valid_o !== 1'b1 && n < 20);
    valid_i = 1'b0;
    chk("bp_latency", 256'(n), 256'(9));
    chk("bp_result_216", result_o, one_lane(3, 32'd216));

    // Wrap: 0xFFFFFFFF + 2 = 1
    issue(ALU_OP_VMAC_LW, one_lane(0, 32'hFFFF_FFFF), '0, 3'd0);
    issue(ALU_OP_VMAC_EN, one_lane(0, 32'd1) | one_lane(1, 32'd1),
          one_lane(0, 32'd1) | one_lane(1, 32'd1), 3'd0);
    wait_mac();
    issue(ALU_OP_VMAC_SW, '0, '0, 3'd0);
    chk("wrap_result", result_o, one_lane(0, 32'd1));

    // Flush at MAC cycle 4
    issue(ALU_OP_VMAC_EN, ramp(1, 0), ramp(1, 0), 3'd0);
    for (int k = 0; k < 4; k++) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_ready", 256'(ready_o), 256'(1));
    issue(ALU_OP_VMAC_SW, '0, '0, 3'd0);
    chk("flush_acc_kept", result_o, one_lane(0, 32'd1));
    tick();

    // Non-VMAC opcode is ignored
    issue(ALU_OP_ADD, ramp(9, 3), ramp(5, 1), 3'd0);
    chk("add_rvalid", 256'(result_valid_o), 256'(0));
    chk("add_ready", 256'(ready_o), 256'(1));

    // Flush in IDLE blocks an SW
    flush_i = 1'b1;
    issue(ALU_OP_VMAC_SW, '0, '0, 3'd0);
    flush_i = 1'b0;
    chk("idle_flush_block", 256'(result_valid_o), 256'(0));
    issue(ALU_OP_VMAC_SW, '0, '0, 3'd0);
    chk("add_no_change", result_o, one_lane(0, 32'd1));

    // Reset mid-MAC discards the op and clears everything
    issue(ALU_OP_VMAC_LW, ramp(1, 1), '0, 3'd0);
    issue(ALU_OP_VMAC_EN, ramp(3, 0), ramp(3, 0), 3'd5);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("midrst_ready", 256'(ready_o), 256'(1));
    chk("midrst_rvalid", 256'(result_valid_o), 256'(0));
    tick();
    rst = 1'b1;
    tick();
    issue(ALU_OP_VMAC_SW, '0, '0, 3'd0);
    chk("midrst_sw_zero", result_o, '0);
    chk("midrst_sw_valid", 256'(result_valid_o), 256'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
